// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, unsigned WIDTH-bit operands.
// Latency is WIDTH shifts plus one subtract per quotient 1 bit.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SUB,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   trial;

  assign trial = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

  // Next state and datapath updates for one division step.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d = divisor;
          cnt_d = CW'(WIDTH);
          if (divisor == '0) begin
            rem_d   = {1'b0, dividend};
            quo_d   = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = dividend;
            dbz_d   = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        rem_d = trial;
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (trial >= {1'b0, dvs_q}) begin
          state_d = SUB;
        end else if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      SUB: begin
        rem_d    = rem_q - {1'b0, dvs_q};
        quo_d[0] = 1'b1;
        state_d  = (cnt_q == '0) ? DONE : SHIFT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  // State, datapath and handshake registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q[WIDTH-1:0];
  assign div_by_zero = dbz_q;

endmodule
